// File: rtl/regs.sv
// Integer register file x0..x31 for the RV32I core: one write port from execute,
// two bypassed read ports to decode and one committed-state debug read port.
module regs #(
    parameter int                    DATA_W    = 32,
    parameter int                    ADDR_W    = 5,
    parameter logic [DATA_W-1:0]     RESET_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              rd_wen_i,
    input  logic [ADDR_W-1:0] reg1_raddr_i,
    input  logic [ADDR_W-1:0] reg2_raddr_i,
    output logic [DATA_W-1:0] reg1_rdata_o,
    output logic [DATA_W-1:0] reg2_rdata_o,
    input  logic [ADDR_W-1:0] dbg_raddr_i,
    output logic [DATA_W-1:0] dbg_rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_en_s;

    assign wr_en_s = rd_wen_i && (rd_addr_i != {ADDR_W{1'b0}});

    // Decode-side read: x0 is hardwired zero, a same-cycle retiring write wins.
    function automatic logic [DATA_W-1:0] bypass_read(
        input logic [ADDR_W-1:0] raddr,
        input logic              wen,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] val;
        if (raddr == {ADDR_W{1'b0}}) begin
            val = {DATA_W{1'b0}};
        end else if (wen && (waddr == raddr)) begin
            val = wdata;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Storage array; entry 0 is held at zero and never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= {DATA_W{1'b0}};
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VAL;
            end
        end else begin
            if (wr_en_s) begin
                mem_q[rd_addr_i] <= rd_data_i;
            end
        end
    end

    // Read ports; all outputs are forced to zero while reset is asserted.
    always_comb begin
        reg1_rdata_o = {DATA_W{1'b0}};
        reg2_rdata_o = {DATA_W{1'b0}};
        dbg_rdata_o  = {DATA_W{1'b0}};
        if (rst_n) begin
            reg1_rdata_o = bypass_read(reg1_raddr_i, rd_wen_i, rd_addr_i, rd_data_i,
                                       mem_q[reg1_raddr_i]);
            reg2_rdata_o = bypass_read(reg2_raddr_i, rd_wen_i, rd_addr_i, rd_data_i,
                                       mem_q[reg2_raddr_i]);
            if (dbg_raddr_i == {ADDR_W{1'b0}}) begin
                dbg_rdata_o = {DATA_W{1'b0}};
            end else begin
                dbg_rdata_o = mem_q[dbg_raddr_i];
            end
        end else begin
            reg1_rdata_o = {DATA_W{1'b0}};
            reg2_rdata_o = {DATA_W{1'b0}};
            dbg_rdata_o  = {DATA_W{1'b0}};
        end
    end

endmodule
